wr_resp_monitor: RTL
====================

Name: wr_resp_monitor

Overview:
- Sits downstream of the HBM write engine on the same AXI port and consumes the B (write-response) channel.
- Snoops AW handshakes to track outstanding writes.
- Counts and classifies responses, and measures cycles from start to the final response.
- Reports per-sample results to the host-side parameter/result logic alongside the engine's own end_of_exec and lat_timer_sum.

Parameters:
ID_WIDTH, 5, width of BID / expected ID
OUTST_WIDTH, 16, width of outstanding-write counter
TIMEOUT_CYCLES, 65536, idle cycles without a response before abort; 0 disables timeout

Ports:
clk  in  1  core clock, same domain as the write engine
rst_n  in  1  reset, asynchronous, active-low
start  in  1  sample start pulse (same pulse given to the engine)
num_mem_ops  in  64  expected response count, sampled on accepted start
aw_fire  in  1  snooped AWVALID&AWREADY of the engine
m_axi_BVALID  in  1  response valid
m_axi_BREADY  in  1  snooped BREADY (the engine ties it to 1)
m_axi_BRESP  in  2  response code
m_axi_BID  in  ID_WIDTH  response ID
exp_id  in  ID_WIDTH  expected BID (used only with the optional feature)
busy  out  1  high in RUN
done  out  1  one-cycle pulse at sample end
timeout  out  1  sticky until next accepted start: sample aborted by timeout
resp_cnt  out  64  responses received this sample
err_cnt  out  32  non-OKAY (or mismatched) responses this sample
first_err_valid  out  1  an error was captured
first_err_resp  out  2  BRESP of first error
first_err_id  out  ID_WIDTH  BID of first error
outst_cnt  out  OUTST_WIDTH  current outstanding writes
outst_max  out  OUTST_WIDTH  peak outstanding this sample
proto_err  out  1  sticky: response with zero outstanding, or counter overflow
cycle_cnt  out  64  cycles spent in RUN

Behaviour:
- **Reset:** asynchronous assertion; all outputs and counters are 0; state is IDLE.
- **Definitions:** b_fire = m_axi_BVALID & m_axi_BREADY. OKAY is BRESP==2'b00 only; 01/10/11 all count as errors.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - start=1 latches num_mem_ops.
  - Clears resp_cnt, err_cnt, first_err_*, outst_cnt, outst_max, proto_err, timeout, cycle_cnt and the idle counter.
  - Goes to RUN, or to DONE directly if num_mem_ops==0.
- **RUN:**
  - busy=1; cycle_cnt += 1 every cycle.
  - b_fire: resp_cnt += 1 and the idle counter clears.
  - Non-OKAY response: err_cnt += 1 (saturating). On the first error, first_err_resp and first_err_id are registered and first_err_valid is set.
  - Transition to DONE in the cycle after the b_fire that makes resp_cnt == latched num_mem_ops.
  - If TIMEOUT_CYCLES!=0 and the idle counter reaches TIMEOUT_CYCLES: set timeout and go to DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE. Results hold until the next accepted start.
- **Outstanding tracking** (active in RUN and in IDLE after a start in the same cycle):
  - aw_fire only: +1.
  - b_fire only: −1.
  - Both together: unchanged.
  - b_fire at outst_cnt==0: outst_cnt stays 0 and proto_err is set.
  - Increment at all-ones: saturates and sets proto_err.
  - outst_max updates with a registered compare: max(outst_max, next outst_cnt).
- **Late traffic:** b_fire in IDLE/DONE is ignored for counters but sets proto_err. aw_fire outside RUN is ignored.
- **start outside IDLE** is ignored (no restart mid-sample).
- **Latency:** every counter reflects a handshake one cycle after it.
- **Reset mid-sample:** immediate return to IDLE with all outputs 0; no done pulse.

Optional Feature:
Macro: WR_RESP_ID_CHECK_EN
- **Defined:** a response with BID != exp_id counts as an error even if BRESP==OKAY, and is captured in first_err_* if it is the first error. A response with a non-OKAY BRESP and a wrong BID counts once.
- **Undefined:** exp_id is unused and BID is only captured in first_err_id.

Test Plan:
1. start with num_mem_ops=4; 4 aw_fire, then 4 OKAY b_fire on consecutive cycles → done once; resp_cnt=4, err_cnt=0, outst_max=4, outst_cnt=0, timeout=0.
2. num_mem_ops=3; responses 00, 10 (BID=7), 11 → err_cnt=2, first_err_resp=2'b10, first_err_id=7, first_err_valid=1.
3. Simultaneous aw_fire and b_fire with outst_cnt=2 → outst_cnt stays 2; b_fire with outst_cnt=0 → proto_err=1, outst_cnt=0.
4. TIMEOUT_CYCLES=16, num_mem_ops=2, only 1 response → timeout=1 and done 16 cycles after the last b_fire; resp_cnt=1.
5. num_mem_ops=0 → done in the cycle after start; cycle_cnt=0. A second start during RUN of another sample is ignored (resp_cnt is not cleared).
6. rst_n low mid-RUN → all outputs 0 asynchronously; with WR_RESP_ID_CHECK_EN defined, exp_id=0 and an OKAY response with BID=3 → err_cnt=1.

Source files
------------

// File: rtl/wr_resp_monitor.sv
// wr_resp_monitor: write-response (B channel) monitor for one HBM write-engine
// AXI port. Tracks outstanding writes from snooped AW handshakes, counts and
// classifies responses, measures the cycles a sample spends running, and aborts
// a sample when responses stop arriving for TIMEOUT_CYCLES cycles.
// Optional build macro WR_RESP_ID_CHECK_EN: when defined, a response whose BID
// differs from exp_id is also treated as an error.
module wr_resp_monitor #(
    parameter int ID_WIDTH       = 5,
    parameter int OUTST_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [63:0]            num_mem_ops,
    input  logic                   aw_fire,
    input  logic                   m_axi_BVALID,
    input  logic                   m_axi_BREADY,
    input  logic [1:0]             m_axi_BRESP,
    input  logic [ID_WIDTH-1:0]    m_axi_BID,
    input  logic [ID_WIDTH-1:0]    exp_id,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [63:0]            resp_cnt,
    output logic [31:0]            err_cnt,
    output logic                   first_err_valid,
    output logic [1:0]             first_err_resp,
    output logic [ID_WIDTH-1:0]    first_err_id,
    output logic [OUTST_WIDTH-1:0] outst_cnt,
    output logic [OUTST_WIDTH-1:0] outst_max,
    output logic                   proto_err,
    output logic [63:0]            cycle_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [31:0]            TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
    localparam logic [OUTST_WIDTH-1:0] OUT_ONE     = OUTST_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [63:0]            num_ops_q, num_ops_d;
    logic [63:0]            resp_cnt_q, resp_cnt_d;
    logic [31:0]            err_cnt_q, err_cnt_d;
    logic                   fe_valid_q, fe_valid_d;
    logic [1:0]             fe_resp_q, fe_resp_d;
    logic [ID_WIDTH-1:0]    fe_id_q, fe_id_d;
    logic [OUTST_WIDTH-1:0] outst_q, outst_d;
    logic [OUTST_WIDTH-1:0] outst_max_q, outst_max_d;
    logic                   proto_q, proto_d;
    logic                   timeout_q, timeout_d;
    logic [63:0]            cycle_q, cycle_d;
    // Cycles elapsed since the last response (or the start), counting that cycle.
    logic [31:0]            idle_q, idle_d;

    logic                   b_fire;
    logic                   resp_is_err;
    logic                   start_acc;
    logic                   track;
    logic [OUTST_WIDTH-1:0] out_base;
    logic [OUTST_WIDTH-1:0] max_base;

    assign b_fire    = m_axi_BVALID & m_axi_BREADY;
    assign start_acc = (state_q == ST_IDLE) && start;
    assign track     = (state_q == ST_RUN) || start_acc;
    assign out_base  = start_acc ? '0 : outst_q;
    assign max_base  = start_acc ? '0 : outst_max_q;

`ifdef WR_RESP_ID_CHECK_EN
    assign resp_is_err = (m_axi_BRESP != 2'b00) || (m_axi_BID != exp_id);
`else
    logic unused_exp_id;
    assign unused_exp_id = ^exp_id;
    assign resp_is_err   = (m_axi_BRESP != 2'b00);
`endif

    // State register and all sample counters, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            num_ops_q   <= '0;
            resp_cnt_q  <= '0;
            err_cnt_q   <= '0;
            fe_valid_q  <= 1'b0;
            fe_resp_q   <= '0;
            fe_id_q     <= '0;
            outst_q     <= '0;
            outst_max_q <= '0;
            proto_q     <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_q     <= '0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            num_ops_q   <= num_ops_d;
            resp_cnt_q  <= resp_cnt_d;
            err_cnt_q   <= err_cnt_d;
            fe_valid_q  <= fe_valid_d;
            fe_resp_q   <= fe_resp_d;
            fe_id_q     <= fe_id_d;
            outst_q     <= outst_d;
            outst_max_q <= outst_max_d;
            proto_q     <= proto_d;
            timeout_q   <= timeout_d;
            cycle_q     <= cycle_d;
            idle_q      <= idle_d;
        end
    end

    // Next-state logic: sample sequencing, response accounting and outstanding tracking.
    always_comb begin
        state_d     = state_q;
        num_ops_d   = num_ops_q;
        resp_cnt_d  = resp_cnt_q;
        err_cnt_d   = err_cnt_q;
        fe_valid_d  = fe_valid_q;
        fe_resp_d   = fe_resp_q;
        fe_id_d     = fe_id_q;
        outst_d     = outst_q;
        outst_max_d = outst_max_q;
        proto_d     = proto_q;
        timeout_d   = timeout_q;
        cycle_d     = cycle_q;
        idle_d      = idle_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_ops_d  = num_mem_ops;
                    resp_cnt_d = '0;
                    err_cnt_d  = '0;
                    fe_valid_d = 1'b0;
                    fe_resp_d  = '0;
                    fe_id_d    = '0;
                    proto_d    = 1'b0;
                    timeout_d  = 1'b0;
                    cycle_d    = '0;
                    idle_d     = 32'd1;
                    state_d    = (num_mem_ops == 64'd0) ? ST_DONE : ST_RUN;
                end else if (b_fire) begin
                    proto_d = 1'b1;
                end
            end
            ST_RUN: begin
                cycle_d = cycle_q + 64'd1;
                if (b_fire) begin
                    resp_cnt_d = resp_cnt_q + 64'd1;
                    idle_d     = 32'd1;
                    if (resp_is_err) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 32'd1;
                        end
                        if (!fe_valid_q) begin
                            fe_valid_d = 1'b1;
                            fe_resp_d  = m_axi_BRESP;
                            fe_id_d    = m_axi_BID;
                        end
                    end
                    if ((resp_cnt_q + 64'd1) == num_ops_q) begin
                        state_d = ST_DONE;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    idle_d = idle_q + 32'd1;
                    if ((idle_q + 32'd1) >= TIMEOUT_LIM) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (b_fire) begin
                    proto_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A start cycle tracks from a cleared counter so its AW handshake is not lost.
        if (track) begin
            outst_d = out_base;
            if (aw_fire && !b_fire) begin
                if (&out_base) begin
                    proto_d = 1'b1;
                end else begin
                    outst_d = out_base + OUT_ONE;
                end
            end else if (b_fire && !aw_fire) begin
                if (out_base == '0) begin
                    proto_d = 1'b1;
                end else begin
                    outst_d = out_base - OUT_ONE;
                end
            end
            outst_max_d = (outst_d > max_base) ? outst_d : max_base;
        end
    end

    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_DONE);
    assign timeout         = timeout_q;
    assign resp_cnt        = resp_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fe_valid_q;
    assign first_err_resp  = fe_resp_q;
    assign first_err_id    = fe_id_q;
    assign outst_cnt       = outst_q;
    assign outst_max       = outst_max_q;
    assign proto_err       = proto_q;
    assign cycle_cnt       = cycle_q;

endmodule
